// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the device using the device-generated clock.
// Both bus lines are driven through open-drain enables.
// Reports the device ACK, or a timeout, with a one-cycle done pulse.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  // The start bit goes out in the last inhibit cycle, then the clock is released.
  localparam logic [CW-1:0] INH_DATA = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] INH_END  = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_END   = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INHIBIT   = 3'd1;
  localparam logic [2:0] SEND      = 3'd2;
  localparam logic [2:0] ACK       = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  logic [2:0]    state;
  logic [2:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          fall;
  logic          clk_level;
  logic          data_level;
  logic [9:0]    shreg;
  logic [3:0]    bitcnt;
  logic [CW-1:0] cnt;
  logic          ack_ok_r;
  logic          idle_seen;

  // Bring the raw bus levels into the clk domain; idle bus level is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign fall       = (clk_sync[2:1] == 2'b10);
  assign clk_level  = clk_sync[1];
  assign data_level = data_sync[1];

  // Transfer sequencer: inhibit, clock out the frame, collect ACK, wait for bus idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
      timeout     <= 1'b0;
      shreg       <= '0;
      bitcnt      <= '0;
      cnt         <= '0;
      ack_ok_r    <= 1'b0;
      idle_seen   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx_ready    <= 1'b1;
          busy        <= 1'b0;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (tx_valid && tx_ready) begin
            shreg      <= {1'b1, ~^tx_data, tx_data};
            bitcnt     <= '0;
            cnt        <= '0;
            ack_ok_r   <= 1'b0;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            state      <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (cnt == INH_DATA) begin
            ps2_data_oe <= 1'b1;
          end
          if (cnt == INH_END) begin
            ps2_clk_oe <= 1'b0;
            cnt        <= '0;
            state      <= SEND;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        SEND: begin
          if (fall) begin
            ps2_data_oe <= ~shreg[0];
            shreg       <= {1'b0, shreg[9:1]};
            bitcnt      <= bitcnt + 4'd1;
            cnt         <= '0;
            if (bitcnt == 4'd9) begin
              state <= ACK;
            end
          end else if (cnt == TO_END) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b1;
            ack_ok      <= 1'b0;
            timeout     <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ACK: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (fall) begin
            ack_ok_r  <= ~data_level;
            cnt       <= '0;
            idle_seen <= 1'b0;
            state     <= WAIT_IDLE;
          end else if (cnt == TO_END) begin
            done    <= 1'b1;
            ack_ok  <= 1'b0;
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        WAIT_IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (fall) begin
            cnt       <= '0;
            idle_seen <= 1'b0;
          end else if (clk_level && data_level && idle_seen) begin
            done    <= 1'b1;
            ack_ok  <= ack_ok_r;
            timeout <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (cnt == TO_END) begin
            done    <= 1'b1;
            ack_ok  <= 1'b0;
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt       <= cnt + CW'(1);
            idle_seen <= clk_level && data_level;
          end
        end

        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: device BFM on a wired-AND bus plus a done scoreboard.
module tb_ps2_host_tx;

  localparam int INH = 8;
  localparam int TO  = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       dev_clk;
  logic       dev_data;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       timeout;

  int checks     = 0;
  int errors     = 0;
  int done_count = 0;
  int exp_done   = 0;
  int done_cyc   = 0;
  int accept_cyc = 0;
  int ready_bad  = 0;
  int cyc        = 0;
  logic [1:0] sb[$];

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .ack_ok     (ack_ok),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Open-drain bus: either side can pull a line low.
  assign ps2_clk  = ~ps2_clk_oe & dev_clk;
  assign ps2_data = ~ps2_data_oe & dev_data;

  // Free-running cycle count used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse pops the expected {ack_ok, timeout}.
  always @(negedge clk) begin
    if (done) begin
      logic [1:0] e;
      done_count++;
      done_cyc = cyc;
      checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("ack_ok", 32'(ack_ok), 32'(e[1]));
        checkOutput("timeout", 32'(timeout), 32'(e[0]));
      end
      checkOutput("ready_at_done", 32'(tx_ready), 32'd0);
      checkOutput("busy_at_done", 32'(busy), 32'd0);
    end
  end

  // Watch for accepts and for tx_ready while a transfer is in flight.
  always @(negedge clk) begin
    if (!reset && tx_valid && tx_ready) accept_cyc = cyc;
    if (busy && tx_ready) ready_bad++;
  end

  function automatic logic [10:0] expFrame(input logic [7:0] b);
    int ones;
    logic p;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    p = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Request a byte and record what the done pulse must report.
  task automatic applyStimulus(input logic [7:0] b, input logic exp_ack, input logic exp_to);
    int n;
    sb.push_back({exp_ack, exp_to});
    exp_done++;
    tx_data  = b;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_wait", 32'(n < 100), 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device BFM: measures inhibit, clocks the frame, captures on rising edges.
  task automatic deviceFrame(input logic do_clock, input logic do_ack, input int rst_fall,
                             input int junk_fall, output logic [10:0] frame, output int inh);
    int n;
    frame = '0;
    inh   = 0;
    n     = 0;
    while (!ps2_clk_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("request_seen", 32'(n < 100), 32'd1);
    while (ps2_clk_oe && inh < 100) begin
      inh++;
      @(negedge clk);
    end
    frame[0] = ps2_data;
    if (!do_clock) return;
    waitCycles(5);
    for (int i = 1; i <= 11; i++) begin
      dev_clk = 1'b0;
      if (i == rst_fall) begin
        waitCycles(5);
        checkOutput("data_oe_before_reset", 32'(ps2_data_oe), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("clk_oe_async_reset", 32'(ps2_clk_oe), 32'd0);
        checkOutput("data_oe_async_reset", 32'(ps2_data_oe), 32'd0);
        dev_clk = 1'b1;
        sb.delete();
        exp_done--;
        waitCycles(3);
        reset = 1'b0;
        return;
      end
      if (i == junk_fall) begin
        waitCycles(2);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        waitCycles(2);
        tx_valid = 1'b0;
        waitCycles(6);
      end else begin
        waitCycles(10);
      end
      dev_clk = 1'b1;
      if (i <= 10) frame[i] = ps2_data;
      if (i == 11) begin
        dev_data = 1'b1;
      end else if (i == 10) begin
        waitCycles(5);
        if (do_ack) dev_data = 1'b0;
        waitCycles(5);
      end else begin
        waitCycles(10);
      end
    end
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (done_count < exp_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_count", 32'(done_count), 32'(exp_done));
  endtask

  initial begin
    logic [10:0] frame;
    int inh;
    int m;
    int extra;

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    waitCycles(3);
    checkOutput("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    checkOutput("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    checkOutput("rst_tx_ready", 32'(tx_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_ack_ok", 32'(ack_ok), 32'd0);
    checkOutput("rst_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    waitCycles(2);

    $display("[TB] send 0xED with ACK");
    applyStimulus(8'hED, 1'b1, 1'b0);
    deviceFrame(1'b1, 1'b1, 0, 0, frame, inh);
    checkOutput("inhibit_len", 32'(inh), 32'(INH));
    checkOutput("frame_ED", 32'(frame), 32'(expFrame(8'hED)));
    waitDone();
    waitCycles(5);

    $display("[TB] back-to-back 0x00 then 0xFF");
    applyStimulus(8'h00, 1'b1, 1'b0);
    deviceFrame(1'b1, 1'b1, 0, 0, frame, inh);
    checkOutput("frame_00", 32'(frame), 32'(expFrame(8'h00)));
    applyStimulus(8'hFF, 1'b1, 1'b0);
    checkOutput("b2b_gap", 32'(accept_cyc - done_cyc), 32'd1);
    deviceFrame(1'b1, 1'b1, 0, 0, frame, inh);
    checkOutput("frame_FF", 32'(frame), 32'(expFrame(8'hFF)));
    waitDone();
    checkOutput("ready_low_busy", 32'(ready_bad), 32'd0);
    waitCycles(5);

    $display("[TB] full frame without ACK");
    applyStimulus(8'h3C, 1'b0, 1'b0);
    deviceFrame(1'b1, 1'b0, 0, 0, frame, inh);
    checkOutput("frame_3C", 32'(frame), 32'(expFrame(8'h3C)));
    waitDone();
    waitCycles(5);

    $display("[TB] device never clocks");
    applyStimulus(8'hFF, 1'b0, 1'b1);
    deviceFrame(1'b0, 1'b0, 0, 0, frame, inh);
    m = 0;
    while (!done && m < 200) begin
      @(negedge clk);
      m++;
    end
    checkOutput("timeout_latency", 32'(m), 32'(TO));
    checkOutput("to_clk_oe", 32'(ps2_clk_oe), 32'd0);
    checkOutput("to_data_oe", 32'(ps2_data_oe), 32'd0);
    @(negedge clk);
    checkOutput("to_ready", 32'(tx_ready), 32'd1);
    checkOutput("to_busy", 32'(busy), 32'd0);
    waitDone();
    waitCycles(5);

    $display("[TB] request while busy is ignored");
    applyStimulus(8'hF4, 1'b1, 1'b0);
    deviceFrame(1'b1, 1'b1, 0, 4, frame, inh);
    checkOutput("frame_F4", 32'(frame), 32'(expFrame(8'hF4)));
    waitDone();
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (ps2_clk_oe || busy) extra++;
    end
    checkOutput("no_second_frame", 32'(extra), 32'd0);

    $display("[TB] reset mid-frame then resend");
    applyStimulus(8'hA5, 1'b1, 1'b0);
    deviceFrame(1'b1, 1'b1, 4, 0, frame, inh);
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(tx_ready), 32'd1);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);
    applyStimulus(8'hED, 1'b1, 1'b0);
    deviceFrame(1'b1, 1'b1, 0, 0, frame, inh);
    checkOutput("inhibit_len2", 32'(inh), 32'(INH));
    checkOutput("frame_ED2", 32'(frame), 32'(expFrame(8'hED)));
    waitDone();
    waitCycles(5);

    checkOutput("ready_low_busy_end", 32'(ready_bad), 32'd0);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
